// File: rtl/edge_pulse_spacer_pkg.sv
// Shared types for the edge pulse spacer: the two-state gap FSM encoding.
package edge_pulse_spacer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

endpackage

// File: rtl/edge_pulse_spacer.sv
// Buffers single-cycle event pulses and re-emits them one at a time, at least
// GAP_CYCLES apart, so a downstream CDC handshake never sees coalesced pulses.
module edge_pulse_spacer
  import edge_pulse_spacer_pkg::*;
#(
  parameter int CNT_WIDTH  = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic                 edge_i,
  output logic                 edge_o,
  output logic [CNT_WIDTH-1:0] pending_o,
  output logic                 busy_o,
  output logic                 overflow_o
);

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 2) begin : g_gap_check
    $error("edge_pulse_spacer: GAP_CYCLES must be >= 2");
  end

  state_t               r_state;
  state_t               w_state_next;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [GAP_W-1:0]     w_gap_next;
  logic [CNT_WIDTH-1:0] r_pending;
  logic [CNT_WIDTH-1:0] w_pending_next;
  logic                 r_overflow;
  logic                 w_overflow_next;
  logic                 r_edge;
  logic                 w_inc;
  logic                 w_issue;

  assign w_inc   = edge_i & en_i & ~clear_i;
  // An idle, empty block passes an incoming event straight through.
  assign w_issue = (r_gap_cnt == '0) & ((r_pending != '0) | w_inc) & ~clear_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_gap_cnt  <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_edge     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_gap_cnt  <= w_gap_next;
      r_pending  <= w_pending_next;
      r_overflow <= w_overflow_next;
      r_edge     <= w_issue;
    end
  end

  // GAP holds for one cycle at gap_cnt==0 so a back-to-back issue can reload it.
  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_cnt;
    if (clear_i) begin
      w_state_next = IDLE;
      w_gap_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            w_state_next = GAP;
            w_gap_next   = GAP_LOAD;
          end
        end
        GAP: begin
          if (r_gap_cnt != '0) begin
            w_gap_next = r_gap_cnt - GAP_W'(1);
          end else if (w_issue) begin
            w_gap_next = GAP_LOAD;
          end else begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_gap_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_pending_next  = r_pending;
    w_overflow_next = r_overflow;
    if (clear_i) begin
      w_pending_next  = '0;
      w_overflow_next = 1'b0;
    end else if (w_inc && !w_issue) begin
      if (r_pending == CNT_MAX) begin
        w_overflow_next = 1'b1;
      end else begin
        w_pending_next = r_pending + CNT_WIDTH'(1);
      end
    end else if (!w_inc && w_issue) begin
      w_pending_next = r_pending - CNT_WIDTH'(1);
    end
  end

  assign edge_o     = r_edge;
  assign pending_o  = r_pending;
  assign overflow_o = r_overflow;
  assign busy_o     = (r_pending != '0) | (r_state == GAP) | r_edge;

endmodule

// File: tb/tb_edge_pulse_spacer.sv
// Randomized and directed bench for edge_pulse_spacer, checked against a
// time-based reference model (event count plus time of last emitted pulse).
module tb_edge_pulse_spacer;

  localparam int CW  = 3;
  localparam int GAP = 4;
  localparam int MAXP = (1 << CW) - 1;

  logic          clk_i;
  logic          rstn_i;
  logic          en_i;
  logic          clear_i;
  logic          edge_i;
  logic          edge_o;
  logic [CW-1:0] pending_o;
  logic          busy_o;
  logic          overflow_o;

  int n_checks;
  int n_fail;

  // reference model state
  int cyc;
  int m_pend;
  int m_last;
  bit m_ovf;
  bit m_edge;

  edge_pulse_spacer #(
    .CNT_WIDTH  (CW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .clear_i    (clear_i),
    .edge_i     (edge_i),
    .edge_o     (edge_o),
    .pending_o  (pending_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_last = -1000;
    m_ovf  = 1'b0;
    m_edge = 1'b0;
  endtask

  function automatic int exp_busy();
    int d;
    d = cyc - m_last;
    return ((m_pend != 0) || m_edge || (d >= 1 && d <= GAP)) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".edge"},     int'(edge_o),     int'(m_edge));
    check_val({tag, ".pending"},  int'(pending_o),  m_pend);
    check_val({tag, ".overflow"}, int'(overflow_o), int'(m_ovf));
    check_val({tag, ".busy"},     int'(busy_o),     exp_busy());
  endtask

  // One clock cycle: drive inputs, advance model across the edge, compare.
  task automatic step(input bit e, input bit en, input bit clr, input string tag);
    bit inc;
    bit issue;
    edge_i  = e;
    en_i    = en;
    clear_i = clr;
    @(posedge clk_i);
    inc   = e && en && !clr;
    issue = (cyc - m_last >= GAP) && (m_pend > 0 || inc) && !clr;
    if (clr) begin
      model_reset();
    end else begin
      m_edge = issue;
      if (issue) m_last = cyc;
      m_pend = m_pend + int'(inc) - int'(issue);
      if (m_pend > MAXP) begin
        m_pend = MAXP;
        m_ovf  = 1'b1;
      end
    end
    cyc++;
    #1;
    $display("txn %s cyc=%0d edge_i=%0b en=%0b clr=%0b -> edge_o=%0b pend=%0d busy=%0b ovf=%0b",
             tag, cyc, e, en, clr, edge_o, pending_o, busy_o, overflow_o);
    check_all(tag);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, tag);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic async_reset(input string tag);
    rstn_i = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    model_reset();
    rstn_i  = 1'b0;
    en_i    = 1'b0;
    clear_i = 1'b0;
    edge_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    @(negedge clk_i);
    rstn_i = 1'b1;

    // single event from idle
    idle_steps(3, "idle");
    step(1'b1, 1'b1, 1'b0, "single");
    check_val("single.latency", int'(edge_o), 1);
    idle_steps(6, "single_tail");

    // three back-to-back events
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "burst3");
    idle_steps(12, "burst3_drain");

    // saturation
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, "hold");
    check_val("hold.sat_pending", int'(pending_o), MAXP);
    check_val("hold.sat_overflow", int'(overflow_o), 1);
    idle_steps(40, "hold_drain");
    check_val("hold.drained", int'(pending_o), 0);

    // en_i low ignores edge_i while backlog drains
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, "fill");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, "en_off");
    idle_steps(4, "en_off_tail");

    // clear during gap with backlog and overflow
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, "prefill");
    step(1'b1, 1'b1, 1'b1, "clear");
    check_val("clear.pending", int'(pending_o), 0);
    step(1'b1, 1'b1, 1'b0, "after_clear");
    check_val("after_clear.edge", int'(edge_o), 1);
    idle_steps(6, "clear_tail");

    // reset mid-gap with backlog
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, "pre_rst");
    async_reset("async_rst");
    idle_steps(2, "post_rst");
    step(1'b1, 1'b1, 1'b0, "post_rst_edge");
    idle_steps(5, "post_rst_tail");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit e, en, clr;
      e   = ($urandom_range(0, 99) < 35);
      en  = ($urandom_range(0, 99) < 90);
      clr = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 999) < 3) async_reset("rand_rst");
      step(e, en, clr, "rand");
    end
    idle_steps(40, "final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
